// File: rtl/io_pkg.sv
// Shared types and opcode field decode for the IO port serializer slice.
// Holds the FSM state enum, opcode class/size fields and byte-width constants.
package io_pkg;

  typedef enum logic [2:0] {
    IDLE,
    STORE,
    LOAD_REQ,
    LOAD_WAIT,
    WRITEBACK
  } ioState_t;

  localparam int BYTE_W   = 8;
  localparam int OPCODE_W = 4;

  // Opcode bits [3:2] select the class; anything not listed is a port load.
  localparam logic [1:0] OP_STORE  = 2'b01;
  localparam logic [1:0] OP_STATUS = 2'b11;

  function automatic logic [1:0] opClass(input logic [OPCODE_W-1:0] op);
    return op[3:2];
  endfunction

  function automatic logic [1:0] opSize(input logic [OPCODE_W-1:0] op);
    return op[1:0];
  endfunction

  function automatic int unsigned clampBytes(input logic [1:0] size, input int unsigned maxBytes);
    int unsigned n;
    n = 32'd1 << size;
    return (n < maxBytes) ? n : maxBytes;
  endfunction

endpackage

// File: rtl/io_port_serializer_if.sv
// Command, byte-port and register-writeback bundle for io_port_serializer.
// The master modport is the serializer side; slave is the surrounding system.
interface io_port_serializer_if #(
  parameter int DATABITWIDTH    = 16,
  parameter int PORTBYTEWIDTH   = 8,
  parameter int REGADDRBITWIDTH = 4
);
  logic                         CommandInACK;
  logic                         CommandInREQ;
  logic [3:0]                   MinorOpcodeIn;
  logic [REGADDRBITWIDTH-1:0]   RegisterDestIn;
  logic [DATABITWIDTH-1:0]      DataAddrIn;
  logic [PORTBYTEWIDTH*8-1:0]   DataIn;
  logic                         PortTxValid;
  logic                         PortTxReady;
  logic                         PortTxWrite;
  logic [DATABITWIDTH-1:0]      PortTxAddr;
  logic [7:0]                   PortTxData;
  logic                         PortRxValid;
  logic [7:0]                   PortRxData;
  logic                         WritebackACK;
  logic                         WritebackREQ;
  logic [REGADDRBITWIDTH-1:0]   WritebackDest;
  logic [DATABITWIDTH-1:0]      WritebackData;
  logic                         TimeoutFlag;

  modport master (
    input  CommandInACK, MinorOpcodeIn, RegisterDestIn, DataAddrIn, DataIn,
           PortTxReady, PortRxValid, PortRxData, WritebackREQ,
    output CommandInREQ, PortTxValid, PortTxWrite, PortTxAddr, PortTxData,
           WritebackACK, WritebackDest, WritebackData, TimeoutFlag
  );

  modport slave (
    output CommandInACK, MinorOpcodeIn, RegisterDestIn, DataAddrIn, DataIn,
           PortTxReady, PortRxValid, PortRxData, WritebackREQ,
    input  CommandInREQ, PortTxValid, PortTxWrite, PortTxAddr, PortTxData,
           WritebackACK, WritebackDest, WritebackData, TimeoutFlag
  );
endinterface

// File: rtl/io_byte_lane_select.sv
// Combinational byte-lane mux: picks one byte of the latched store payload.
module io_byte_lane_select #(
  parameter int PORTBYTEWIDTH = 8,
  parameter int LANE_W        = 3
) (
  input  logic [PORTBYTEWIDTH*8-1:0] dataIn,
  input  logic [LANE_W-1:0]          lane,
  output logic [7:0]                 byteOut
);
  always_comb begin
    byteOut = '0;
    for (int k = 0; k < PORTBYTEWIDTH; k++) begin
      if (lane == LANE_W'(k)) byteOut = dataIn[k*8 +: 8];
    end
  end
endmodule

// File: rtl/io_port_serializer.sv
// Serializes store/load commands into byte-wide port beats and returns load/status data
// as a register writeback. Optional watchdog: define IO_PORT_SERIALIZER_TIMEOUT_EN.
module io_port_serializer
  import io_pkg::*;
#(
  parameter int DATABITWIDTH    = 16,
  parameter int PORTBYTEWIDTH   = 8,
  parameter int REGADDRBITWIDTH = 4,
  parameter int TIMEOUTCYCLES   = 255
) (
  input logic                  clk,
  input logic                  async_rst_n,
  input logic                  clk_en,
  io_port_serializer_if.master bus
);
  localparam int CNT_W    = 4;
  localparam int LANE_W   = (PORTBYTEWIDTH > 1) ? $clog2(PORTBYTEWIDTH) : 1;
  localparam int WB_BYTES = DATABITWIDTH / BYTE_W;

  ioState_t                        state, stateNext;
  logic [CNT_W-1:0]                reqN, reqCnt, rxCnt, cmdN;
  logic [REGADDRBITWIDTH-1:0]      destReg;
  logic [DATABITWIDTH-1:0]         addrReg, wbData, storeCount, beatAddr;
  logic [PORTBYTEWIDTH*BYTE_W-1:0] dataReg;
  logic [LANE_W-1:0]               laneIdx;
  logic [7:0]                      laneByte;
  logic [1:0]                      cmdClass;
  logic cmdXfer, txXfer, rxAccept, wbXfer, lastReq, lastRx, timeoutHit;

  assign cmdClass = opClass(bus.MinorOpcodeIn);
  assign cmdN     = (cmdClass == OP_STORE)
                    ? CNT_W'(clampBytes(opSize(bus.MinorOpcodeIn), PORTBYTEWIDTH))
                    : CNT_W'(clampBytes(opSize(bus.MinorOpcodeIn), WB_BYTES));

  assign cmdXfer  = (state == IDLE) && bus.CommandInACK && clk_en;
  assign txXfer   = ((state == STORE) || (state == LOAD_REQ)) && bus.PortTxReady && clk_en;
  assign rxAccept = ((state == LOAD_REQ) || (state == LOAD_WAIT)) && bus.PortRxValid && clk_en;
  assign wbXfer   = (state == WRITEBACK) && bus.WritebackREQ && clk_en;
  assign lastReq  = (reqCnt == reqN - CNT_W'(1));
  assign lastRx   = (rxCnt == reqN - CNT_W'(1));

  // Beat address wraps at the address width; the lane index wraps at the payload width.
  assign beatAddr = addrReg + DATABITWIDTH'(reqCnt);
  assign laneIdx  = LANE_W'(beatAddr % DATABITWIDTH'(PORTBYTEWIDTH));

  io_byte_lane_select #(
    .PORTBYTEWIDTH (PORTBYTEWIDTH),
    .LANE_W        (LANE_W)
  ) u_laneSelect (
    .dataIn  (dataReg),
    .lane    (laneIdx),
    .byteOut (laneByte)
  );

  always_ff @(posedge clk or negedge async_rst_n) begin
    if (!async_rst_n) state <= IDLE;
    else if (clk_en)  state <= stateNext;
  end

  always_comb begin
    stateNext        = state;
    bus.CommandInREQ = 1'b0;
    bus.PortTxValid  = 1'b0;
    bus.PortTxWrite  = 1'b0;
    bus.WritebackACK = 1'b0;
    case (state)
      IDLE: begin
        bus.CommandInREQ = 1'b1;
        if (cmdXfer) begin
          if (cmdClass == OP_STORE)       stateNext = STORE;
          else if (cmdClass == OP_STATUS) stateNext = WRITEBACK;
          else                            stateNext = LOAD_REQ;
        end
      end
      STORE: begin
        bus.PortTxValid = 1'b1;
        bus.PortTxWrite = 1'b1;
        if ((txXfer && lastReq) || timeoutHit) stateNext = IDLE;
      end
      LOAD_REQ: begin
        bus.PortTxValid = 1'b1;
        // A final byte arriving alongside the final request skips LOAD_WAIT.
        if ((rxAccept && lastRx) || timeoutHit) stateNext = WRITEBACK;
        else if (txXfer && lastReq)             stateNext = LOAD_WAIT;
      end
      LOAD_WAIT: begin
        if ((rxAccept && lastRx) || timeoutHit) stateNext = WRITEBACK;
      end
      WRITEBACK: begin
        bus.WritebackACK = 1'b1;
        if (wbXfer) stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge async_rst_n) begin
    if (!async_rst_n) begin
      reqN       <= '0;
      reqCnt     <= '0;
      rxCnt      <= '0;
      destReg    <= '0;
      addrReg    <= '0;
      dataReg    <= '0;
      wbData     <= '0;
      storeCount <= '0;
    end else if (clk_en) begin
      if (cmdXfer) begin
        reqN    <= cmdN;
        reqCnt  <= '0;
        rxCnt   <= '0;
        destReg <= bus.RegisterDestIn;
        addrReg <= bus.DataAddrIn;
        dataReg <= bus.DataIn;
        wbData  <= (cmdClass == OP_STATUS) ? storeCount : '0;
      end
      if (txXfer) reqCnt <= reqCnt + CNT_W'(1);
      if (rxAccept) begin
        rxCnt <= rxCnt + CNT_W'(1);
        for (int k = 0; k < WB_BYTES; k++) begin
          if (rxCnt == CNT_W'(k)) wbData[k*8 +: 8] <= bus.PortRxData;
        end
      end
      if (txXfer && lastReq && (state == STORE)) storeCount <= storeCount + DATABITWIDTH'(1);
      if (timeoutHit && (state != STORE)) wbData <= '1;
    end
  end

  assign bus.PortTxAddr    = beatAddr;
  assign bus.PortTxData    = laneByte;
  assign bus.WritebackDest = destReg;
  assign bus.WritebackData = wbData;

`ifdef IO_PORT_SERIALIZER_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUTCYCLES + 1);
  logic [WD_W-1:0] wdCnt;
  logic            wdBusy, wdProgress, timeoutFlagReg;

  // Any accepted beat or received byte counts as progress and restarts the watchdog.
  assign wdBusy     = (state == STORE) || (state == LOAD_REQ) || (state == LOAD_WAIT);
  assign wdProgress = txXfer || rxAccept;
  assign timeoutHit = clk_en && wdBusy && !wdProgress && (wdCnt == WD_W'(TIMEOUTCYCLES - 1));

  always_ff @(posedge clk or negedge async_rst_n) begin
    if (!async_rst_n) begin
      wdCnt          <= '0;
      timeoutFlagReg <= 1'b0;
    end else if (clk_en) begin
      if (!wdBusy || wdProgress || timeoutHit) wdCnt <= '0;
      else                                      wdCnt <= wdCnt + WD_W'(1);
      if (timeoutHit) timeoutFlagReg <= 1'b1;
    end
  end

  assign bus.TimeoutFlag = timeoutFlagReg;
`else
  assign timeoutHit      = 1'b0;
  assign bus.TimeoutFlag = 1'b0;
`endif

endmodule
